// File: rtl/axi_rd_arbiter_if.sv
// Bundles the requester-side AR/R ports and the shared m00_axi AR/R channels of axi_rd_arbiter.
// The master modport is the arbiter's view; slave is the requesters/memory side.
interface axi_rd_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 512
);
    logic [NUM_REQ*ADDR_W-1:0] req_araddr;
    logic [NUM_REQ*8-1:0]      req_arlen;
    logic [NUM_REQ-1:0]        req_arvalid;
    logic [NUM_REQ-1:0]        req_arready;
    logic [DATA_W-1:0]         req_rdata;
    logic                      req_rlast;
    logic [1:0]                req_rresp;
    logic [NUM_REQ-1:0]        req_rvalid;
    logic [NUM_REQ-1:0]        req_rready;

    logic [ADDR_W-1:0]         m00_axi_araddr;
    logic [7:0]                m00_axi_arlen;
    logic [2:0]                m00_axi_arsize;
    logic [1:0]                m00_axi_arburst;
    logic                      m00_axi_arlock;
    logic [3:0]                m00_axi_arcache;
    logic [2:0]                m00_axi_arprot;
    logic                      m00_axi_arvalid;
    logic                      m00_axi_arready;
    logic [DATA_W-1:0]         m00_axi_rdata;
    logic [1:0]                m00_axi_rresp;
    logic                      m00_axi_rlast;
    logic                      m00_axi_rvalid;
    logic                      m00_axi_rready;

    modport master (
        input  req_araddr, req_arlen, req_arvalid, req_rready,
        input  m00_axi_arready, m00_axi_rdata, m00_axi_rresp, m00_axi_rlast, m00_axi_rvalid,
        output req_arready, req_rdata, req_rlast, req_rresp, req_rvalid,
        output m00_axi_araddr, m00_axi_arlen, m00_axi_arsize, m00_axi_arburst, m00_axi_arlock,
        output m00_axi_arcache, m00_axi_arprot, m00_axi_arvalid, m00_axi_rready
    );

    modport slave (
        output req_araddr, req_arlen, req_arvalid, req_rready,
        output m00_axi_arready, m00_axi_rdata, m00_axi_rresp, m00_axi_rlast, m00_axi_rvalid,
        input  req_arready, req_rdata, req_rlast, req_rresp, req_rvalid,
        input  m00_axi_araddr, m00_axi_arlen, m00_axi_arsize, m00_axi_arburst, m00_axi_arlock,
        input  m00_axi_arcache, m00_axi_arprot, m00_axi_arvalid, m00_axi_rready
    );
endinterface

// File: rtl/axi_rd_arbiter.sv
// Round-robin sharing of one AXI4 read port between NUM_REQ load engines; an order FIFO of
// grant indices steers in-order R bursts back to their owners.
//   state | meaning
//   IDLE  | waiting for a request with order-FIFO space; grants combinationally
//   ISSUE | latched burst presented on m00_axi AR until arready
module axi_rd_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 512,
    parameter int MAX_OUTST = 4
) (
    input logic              system_clk,
    input logic              rst,
    axi_rd_arbiter_if.master bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int CNT_W = $clog2(MAX_OUTST + 1);

    typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [IDX_W-1:0]   gnt_q, gnt_d;
    logic [ADDR_W-1:0]  araddr_q, araddr_d;
    logic [7:0]         arlen_q, arlen_d;
    logic [IDX_W-1:0]   fifo_q [MAX_OUTST];
    logic [IDX_W-1:0]   fifo_d [MAX_OUTST];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               gnt_found, grant, push, pop, fifo_empty;
    logic [IDX_W-1:0]   gnt_idx, head;
    logic [NUM_REQ-1:0] arv_rot, rdy_rot;
    int                 idx;

    // first valid requester at or after rr, wrapping
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        arv_rot   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            arv_rot = bus.req_arvalid >> idx;
            if (!gnt_found && arv_rot[0]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDX_W'(idx);
            end
        end
    end

    assign grant = !rst && (state_q == IDLE) && gnt_found && (count_q < CNT_W'(MAX_OUTST));

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        gnt_d    = gnt_q;
        araddr_d = araddr_q;
        arlen_d  = arlen_q;
        push     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (grant) begin
                    gnt_d    = gnt_idx;
                    araddr_d = ADDR_W'(bus.req_araddr >> (int'(gnt_idx) * ADDR_W));
                    arlen_d  = 8'(bus.req_arlen >> (int'(gnt_idx) * 8));
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.m00_axi_arready) begin
                    push    = 1'b1;
                    rr_d    = (int'(gnt_q) == NUM_REQ - 1) ? '0 : gnt_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign fifo_empty = (count_q == '0);
    assign head       = fifo_q[rd_ptr_q];
    assign rdy_rot    = bus.req_rready >> head;
    assign pop        = bus.m00_axi_rvalid && bus.m00_axi_rready && bus.m00_axi_rlast;

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            fifo_d[wr_ptr_q] = gnt_q;
            wr_ptr_d         = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop) count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
    end

    always_ff @(posedge system_clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_q     <= '0;
            gnt_q    <= '0;
            araddr_q <= '0;
            arlen_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            gnt_q    <= gnt_d;
            araddr_q <= araddr_d;
            arlen_q  <= arlen_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // entries are only read while counted, so they need no reset
    always_ff @(posedge system_clk) begin
        fifo_q <= fifo_d;
    end

    assign bus.req_arready     = grant ? (NUM_REQ'(1) << gnt_idx) : '0;
    assign bus.m00_axi_araddr  = araddr_q;
    assign bus.m00_axi_arlen   = arlen_q;
    assign bus.m00_axi_arvalid = (state_q == ISSUE);
    assign bus.m00_axi_arsize  = 3'b110;
    assign bus.m00_axi_arburst = 2'b01;
    assign bus.m00_axi_arlock  = 1'b0;
    assign bus.m00_axi_arcache = 4'b0011;
    assign bus.m00_axi_arprot  = 3'b000;

    assign bus.req_rvalid     = (!fifo_empty && bus.m00_axi_rvalid) ? (NUM_REQ'(1) << head) : '0;
    assign bus.m00_axi_rready = !fifo_empty && rdy_rot[0];
    assign bus.req_rdata      = bus.m00_axi_rdata;
    assign bus.req_rlast      = bus.m00_axi_rlast;
    assign bus.req_rresp      = bus.m00_axi_rresp;
endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Shares the single 512-bit AXI4 read master port of accelerator_control (the m00_axi AR/R channels to DDR/axi_ram) between NUM_REQ internal load engines, e.g. feature loader and weight loader.
- Arbitrates read-address requests round-robin and forwards one burst at a time to AXI.
- Records the grant order in an order FIFO, then steers R beats back to the owning requester.
- Assumes in-order return with a single ID.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- ADDR_W, 32, AXI address width.
- DATA_W, 512, AXI data width.
- MAX_OUTST, 4, order-FIFO depth = maximum outstanding bursts (power of 2).

Ports:
- system_clk  input  1  clock for all logic.
- rst  input  1  synchronous, active-high reset.
- req_araddr  input  NUM_REQ*ADDR_W  per-requester burst address; requester i uses slice i.
- req_arlen  input  NUM_REQ*8  per-requester AXI arlen (beats-1).
- req_arvalid  input  NUM_REQ  request valid.
- req_arready  output  NUM_REQ  request accepted (one-hot pulse).
- req_rdata  output  DATA_W  shared read data to all requesters.
- req_rlast  output  1  last beat of the burst.
- req_rresp  output  2  response, passed through from AXI.
- req_rvalid  output  NUM_REQ  one-hot beat valid for the owning requester.
- req_rready  input  NUM_REQ  requester beat acceptance.
- m00_axi_araddr  output  ADDR_W  AXI read address.
- m00_axi_arlen  output  8  AXI burst length.
- m00_axi_arsize  output  3  constant 3'b110 (64 B).
- m00_axi_arburst  output  2  constant 2'b01 (INCR).
- m00_axi_arlock  output  1  constant 0.
- m00_axi_arcache  output  4  constant 4'b0011.
- m00_axi_arprot  output  3  constant 0.
- m00_axi_arvalid  output  1  AXI address valid.
- m00_axi_arready  input  1  AXI address ready.
- m00_axi_rdata  input  DATA_W  AXI read data.
- m00_axi_rresp  input  2  AXI read response.
- m00_axi_rlast  input  1  AXI last beat.
- m00_axi_rvalid  input  1  AXI beat valid.
- m00_axi_rready  output  1  AXI beat ready.

Behaviour:

Reset (rst=1 at a clock edge):
- m00_axi_arvalid=0, m00_axi_araddr=0, m00_axi_arlen=0.
- req_arready=0.
- Order FIFO emptied (count=0); round-robin pointer rr=0.
- AR FSM returns to IDLE.
- An in-flight burst is abandoned. Its beats after reset are not routed: the FIFO is empty, so m00_axi_rready=0. The system must not reset mid-burst except together with the memory.

AR FSM (states IDLE, ISSUE):
- IDLE, when any req_arvalid is high and count<MAX_OUTST:
  - grant g = first requester with arvalid, searching from rr upward with wrap.
  - Pulse req_arready[g] for exactly this cycle.
  - Latch req_araddr/arlen slice g and g into regs.
  - Go to ISSUE.
- IDLE, when count==MAX_OUTST: no grant is made; req_arready stays 0.
- ISSUE:
  - m00_axi_arvalid=1; address and len are held stable until the handshake.
  - On m00_axi_arready: push g into the order FIFO, set rr=(g+1) mod NUM_REQ, deassert arvalid next cycle, return to IDLE.
- Latency: requester handshake at cycle N gives m00_axi_arvalid high at N+1. Minimum spacing between two grants is 2 cycles (1 burst per 2 clocks).
- A requester's arvalid dropping while not granted is ignored; no grant is issued for it.

Order FIFO:
- Depth MAX_OUTST, entries of width clog2(NUM_REQ).
- count ranges 0..MAX_OUTST; rd/wr pointers wrap modulo MAX_OUTST.
- Simultaneous push and pop: count unchanged, both pointers advance. This is legal even when count==MAX_OUTST, because the push was already gated at grant time.

R routing, with h = FIFO head:
- FIFO non-empty:
  - req_rvalid[h] = m00_axi_rvalid; all other bits 0.
  - m00_axi_rready = req_rready[h].
  - req_rdata, req_rlast, req_rresp driven combinationally from AXI (0 cycle latency).
- FIFO empty: req_rvalid=0 and m00_axi_rready=0.
- Handshake with m00_axi_rlast=1: pop the FIFO; the next beat routes to the new head.
- A non-owner's rready has no effect.
- rresp≠OKAY is passed through unchanged; the arbiter performs no retry.

Test Plan:
1. Single burst: req0 araddr=0x1000, arlen=3, arready tied 1. Expect req_arready[0] for 1 cycle, m00_axi_arvalid next cycle with addr 0x1000 and len 3. Expect 4 beats with req_rvalid=2'b01, rlast on the 4th, FIFO count 1→0.
2. Round-robin: both requesters hold arvalid continuously (req0 0x0, req1 0x8000, arlen=0). Expect AR order req0, req1, req0, req1, with grants every 2 cycles. Expect R beats steered 01, 10, 01, 10.
3. Outstanding limit: memory R withheld, 5 requests from req1. Expect exactly 4 AR handshakes and no req_arready for the 5th. After the first rlast, the 5th is granted within 2 cycles.
4. Requester backpressure: req1 owns the head and holds rready=0 for 5 cycles. Expect m00_axi_rready=0, rdata held by memory, no FIFO pop; req0's rready=1 has no effect.
5. AXI arready stall: arready=0 for 10 cycles during ISSUE. Expect arvalid, addr and len stable, no further req_arready pulses, and rr unchanged until the handshake.
6. Reset mid-operation: assert rst with 2 bursts outstanding and ISSUE active. Next cycle expect arvalid=0, count=0, rr=0, req_rvalid=0, m00_axi_rready=0.
